// File: rtl/seq_bit_serializer_if.sv
// Word-in / bit-out bus of the serializer: parallel valid/ready input side
// plus the serial stream that feeds a downstream sequence detector.
interface seq_bit_serializer_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] din;
    logic             din_valid;
    logic             din_ready;
    logic             x;
    logic             x_valid;
    logic             x_last;

    modport master (
        output din,
        output din_valid,
        input  din_ready,
        input  x,
        input  x_valid,
        input  x_last
    );

    modport slave (
        input  din,
        input  din_valid,
        output din_ready,
        output x,
        output x_valid,
        output x_last
    );
endinterface

// File: rtl/seq_bit_serializer.sv
// Parallel-to-serial front end: one-word holding buffer feeding a shifter,
// emitting one bit per clock with no gap between consecutive words.
module seq_bit_serializer #(
    parameter int   WIDTH     = 8,
    parameter bit   MSB_FIRST = 1'b1,
    parameter logic IDLE_BIT  = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    seq_bit_serializer_if.slave  bus,
    output logic                 busy,
    output logic [7:0]           word_cnt
);
    localparam int BW = $clog2(WIDTH);
    localparam logic [BW-1:0] LAST_IDX = BW'(WIDTH - 1);
    localparam logic [BW-1:0] PRE_LAST = BW'(WIDTH - 2);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state_r;
    logic [WIDTH-1:0] hold_r;
    logic             hold_full_r;
    logic [WIDTH-1:0] sh_r;
    logic [BW-1:0]    bcnt_r;
    logic [7:0]       word_cnt_r;
    logic             x_r;
    logic             x_valid_r;
    logic             x_last_r;
    logic             busy_r;
    logic             accept_s;

    // Bit that leaves the shifter first for a given word.
    function automatic logic first_bit(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? w[WIDTH-1] : w[0];
    endfunction

    // Move a word one position toward the output end.
    function automatic logic [WIDTH-1:0] shift_word(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
    endfunction

    // Ready comes straight from the buffer flag, so an accept and a transfer never coincide.
    assign accept_s = bus.din_valid & ~hold_full_r;

    // Buffer, shifter and FSM; serial outputs are registered one step ahead of the shifter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= IDLE;
            hold_r      <= '0;
            hold_full_r <= 1'b0;
            sh_r        <= '0;
            bcnt_r      <= '0;
            word_cnt_r  <= 8'd0;
            x_r         <= IDLE_BIT;
            x_valid_r   <= 1'b0;
            x_last_r    <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            if (accept_s) begin
                hold_r      <= bus.din;
                hold_full_r <= 1'b1;
            end
            case (state_r)
                IDLE: begin
                    if (hold_full_r) begin
                        state_r     <= SHIFT;
                        sh_r        <= hold_r;
                        hold_full_r <= 1'b0;
                        bcnt_r      <= '0;
                        x_r         <= first_bit(hold_r);
                        x_valid_r   <= 1'b1;
                        x_last_r    <= 1'b0;
                        busy_r      <= 1'b1;
                    end else begin
                        x_r       <= IDLE_BIT;
                        x_valid_r <= 1'b0;
                        x_last_r  <= 1'b0;
                        busy_r    <= accept_s;
                    end
                end
                SHIFT: begin
                    if (bcnt_r == LAST_IDX) begin
                        word_cnt_r <= word_cnt_r + 8'd1;
                        if (hold_full_r) begin
                            sh_r        <= hold_r;
                            hold_full_r <= 1'b0;
                            bcnt_r      <= '0;
                            x_r         <= first_bit(hold_r);
                            x_valid_r   <= 1'b1;
                            x_last_r    <= 1'b0;
                            busy_r      <= 1'b1;
                        end else begin
                            state_r   <= IDLE;
                            x_r       <= IDLE_BIT;
                            x_valid_r <= 1'b0;
                            x_last_r  <= 1'b0;
                            busy_r    <= accept_s;
                        end
                    end else begin
                        sh_r      <= shift_word(sh_r);
                        bcnt_r    <= bcnt_r + {{(BW-1){1'b0}}, 1'b1};
                        x_r       <= first_bit(shift_word(sh_r));
                        x_valid_r <= 1'b1;
                        x_last_r  <= (bcnt_r == PRE_LAST);
                        busy_r    <= 1'b1;
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    x_r       <= IDLE_BIT;
                    x_valid_r <= 1'b0;
                    x_last_r  <= 1'b0;
                    busy_r    <= hold_full_r | accept_s;
                end
            endcase
        end
    end

    assign bus.din_ready = ~hold_full_r;
    assign bus.x         = x_r;
    assign bus.x_valid   = x_valid_r;
    assign bus.x_last    = x_last_r;
    assign busy          = busy_r;
    assign word_cnt      = word_cnt_r;
endmodule

// File: tb/tb_seq_bit_serializer.sv
// Directed self-checking bench for seq_bit_serializer: an MSB-first and an
// LSB-first instance share clock and reset.
module tb_seq_bit_serializer;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       busy_m, busy_l;
    logic [7:0] wc_m, wc_l;
    int         total = 0;
    int         bad = 0;

    seq_bit_serializer_if #(.WIDTH(8)) if_m ();
    seq_bit_serializer_if #(.WIDTH(8)) if_l ();

    seq_bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) u_msb (
        .clk(clk), .rst(rst), .bus(if_m), .busy(busy_m), .word_cnt(wc_m)
    );
    seq_bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) u_lsb (
        .clk(clk), .rst(rst), .bus(if_l), .busy(busy_l), .word_cnt(wc_l)
    );

    always #5 clk = ~clk;

    task automatic do_reset();
        rst = 1'b0;
        if_m.din_valid = 1'b0;
        if_l.din_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        if_m.din_valid = 1'b0;
        if_l.din_valid = 1'b0;
        repeat (2) @(negedge clk);
        total++; if (if_m.din_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", if_m.din_ready); end
        total++; if (if_m.x !== 1'b0) begin bad++; $display("FAIL reset_x got=%b exp=0", if_m.x); end
        total++; if (if_m.x_valid !== 1'b0) begin bad++; $display("FAIL reset_xvalid got=%b exp=0", if_m.x_valid); end
        total++; if (if_m.x_last !== 1'b0) begin bad++; $display("FAIL reset_xlast got=%b exp=0", if_m.x_last); end
        total++; if (busy_m !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy_m); end
        total++; if (wc_m !== 8'd0) begin bad++; $display("FAIL reset_wordcnt got=%0d exp=0", wc_m); end
        total++; if (if_l.x_valid !== 1'b0) begin bad++; $display("FAIL reset_lsb_xvalid got=%b exp=0", if_l.x_valid); end
        rst = 1'b1;
        @(negedge clk);
        total++; if (if_m.din_ready !== 1'b1) begin bad++; $display("FAIL release_ready got=%b exp=1", if_m.din_ready); end
        total++; if (busy_m !== 1'b0) begin bad++; $display("FAIL release_busy got=%b exp=0", busy_m); end
    endtask

    task automatic test_single_word();
        logic [7:0] expseq;
        expseq = 8'b1101_1010;
        do_reset();
        if_m.din = 8'b1101_1010;
        if_m.din_valid = 1'b1;
        @(negedge clk);
        if_m.din_valid = 1'b0;
        total++; if (if_m.din_ready !== 1'b0) begin bad++; $display("FAIL single_ready_low got=%b exp=0", if_m.din_ready); end
        total++; if (if_m.x_valid !== 1'b0) begin bad++; $display("FAIL single_latency got=%b exp=0", if_m.x_valid); end
        total++; if (busy_m !== 1'b1) begin bad++; $display("FAIL single_busy_held got=%b exp=1", busy_m); end
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            total++; if (if_m.x !== expseq[7-i]) begin bad++; $display("FAIL single_bit%0d got=%b exp=%b", i, if_m.x, expseq[7-i]); end
            total++; if (if_m.x_valid !== 1'b1) begin bad++; $display("FAIL single_valid%0d got=%b exp=1", i, if_m.x_valid); end
            total++; if (if_m.x_last !== (i == 7)) begin bad++; $display("FAIL single_last%0d got=%b exp=%b", i, if_m.x_last, (i == 7)); end
            @(negedge clk);
        end
        total++; if (if_m.x_valid !== 1'b0) begin bad++; $display("FAIL single_after_valid got=%b exp=0", if_m.x_valid); end
        total++; if (if_m.x !== 1'b0) begin bad++; $display("FAIL single_after_x got=%b exp=0", if_m.x); end
        total++; if (busy_m !== 1'b0) begin bad++; $display("FAIL single_after_busy got=%b exp=0", busy_m); end
        total++; if (wc_m !== 8'd1) begin bad++; $display("FAIL single_wordcnt got=%0d exp=1", wc_m); end
    endtask

    task automatic test_back_to_back();
        logic [7:0]  words [2];
        logic [15:0] bits;
        logic [3:0]  win;
        logic        will, started;
        int          idx, nbits, gaps, hits;
        words[0] = 8'hDB;
        words[1] = 8'h6D;
        bits = 16'h0000; win = 4'h0;
        idx = 0; nbits = 0; gaps = 0; hits = 0; started = 1'b0;
        do_reset();
        if_m.din = words[0];
        if_m.din_valid = 1'b1;
        for (int cyc = 0; cyc < 60 && nbits < 16; cyc++) begin
            will = if_m.din_valid & if_m.din_ready;
            @(negedge clk);
            if (will) begin
                idx++;
                total++; if (if_m.din_ready !== 1'b0) begin bad++; $display("FAIL b2b_ready_full got=%b exp=0", if_m.din_ready); end
                if (idx < 2) if_m.din = words[idx];
                else if_m.din_valid = 1'b0;
            end
            if (if_m.x_valid) begin
                started = 1'b1;
                bits = {bits[14:0], if_m.x};
                nbits++;
            end else if (started) begin
                gaps++;
            end
        end
        total++; if (nbits !== 16) begin bad++; $display("FAIL b2b_nbits got=%0d exp=16", nbits); end
        total++; if (bits !== 16'hDB6D) begin bad++; $display("FAIL b2b_stream got=%h exp=db6d", bits); end
        total++; if (gaps !== 0) begin bad++; $display("FAIL b2b_gaps got=%0d exp=0", gaps); end
        total++; if (idx !== 2) begin bad++; $display("FAIL b2b_accepts got=%0d exp=2", idx); end
        for (int i = 15; i >= 0; i--) begin
            win = {win[2:0], bits[i]};
            if (i <= 12 && win == 4'b1101) hits++;
        end
        total++; if (hits !== 5) begin bad++; $display("FAIL b2b_1101_hits got=%0d exp=5", hits); end
        @(negedge clk);
        total++; if (wc_m !== 8'd2) begin bad++; $display("FAIL b2b_wordcnt got=%0d exp=2", wc_m); end
        total++; if (busy_m !== 1'b0) begin bad++; $display("FAIL b2b_busy_end got=%b exp=0", busy_m); end
    endtask

    task automatic test_lsb_first();
        logic [7:0] expseq;
        expseq = 8'b1101_0000;
        do_reset();
        if_l.din = 8'h0B;
        if_l.din_valid = 1'b1;
        @(negedge clk);
        if_l.din_valid = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            total++; if (if_l.x !== expseq[7-i]) begin bad++; $display("FAIL lsb_bit%0d got=%b exp=%b", i, if_l.x, expseq[7-i]); end
            total++; if (if_l.x_last !== (i == 7)) begin bad++; $display("FAIL lsb_last%0d got=%b exp=%b", i, if_l.x_last, (i == 7)); end
            @(negedge clk);
        end
        total++; if (if_l.x_valid !== 1'b0) begin bad++; $display("FAIL lsb_after_valid got=%b exp=0", if_l.x_valid); end
        total++; if (wc_l !== 8'd1) begin bad++; $display("FAIL lsb_wordcnt got=%0d exp=1", wc_l); end
    endtask

    task automatic test_reset_mid_word();
        logic [2:0] bits;
        logic       will;
        int         idx, nbits, extra;
        bits = 3'b000; idx = 0; nbits = 0; extra = 0;
        do_reset();
        if_m.din = 8'hA5;
        if_m.din_valid = 1'b1;
        for (int cyc = 0; cyc < 20 && nbits < 3; cyc++) begin
            will = if_m.din_valid & if_m.din_ready;
            @(negedge clk);
            if (will) begin
                idx++;
                if (idx < 2) if_m.din = 8'h3C;
                else if_m.din_valid = 1'b0;
            end
            if (if_m.x_valid) begin
                bits = {bits[1:0], if_m.x};
                nbits++;
            end
        end
        total++; if (bits !== 3'b101) begin bad++; $display("FAIL mid_first_bits got=%b exp=101", bits); end
        total++; if (if_m.din_ready !== 1'b0) begin bad++; $display("FAIL mid_hold_full got=%b exp=0", if_m.din_ready); end
        if_m.din_valid = 1'b0;
        rst = 1'b0;
        #1;
        total++; if (if_m.x !== 1'b0) begin bad++; $display("FAIL mid_async_x got=%b exp=0", if_m.x); end
        total++; if (if_m.x_valid !== 1'b0) begin bad++; $display("FAIL mid_async_valid got=%b exp=0", if_m.x_valid); end
        total++; if (busy_m !== 1'b0) begin bad++; $display("FAIL mid_async_busy got=%b exp=0", busy_m); end
        total++; if (if_m.din_ready !== 1'b1) begin bad++; $display("FAIL mid_async_ready got=%b exp=1", if_m.din_ready); end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        for (int cyc = 0; cyc < 20; cyc++) begin
            @(negedge clk);
            if (if_m.x_valid) extra++;
        end
        total++; if (extra !== 0) begin bad++; $display("FAIL mid_residual_bits got=%0d exp=0", extra); end
        total++; if (wc_m !== 8'd0) begin bad++; $display("FAIL mid_wordcnt got=%0d exp=0", wc_m); end
        total++; if (busy_m !== 1'b0) begin bad++; $display("FAIL mid_busy_after got=%b exp=0", busy_m); end
    endtask

    task automatic test_counter_wrap();
        logic will, prev_last, done;
        int   sent, lasts;
        sent = 0; lasts = 0; prev_last = 1'b0; done = 1'b0;
        do_reset();
        if_m.din = 8'h00;
        if_m.din_valid = 1'b1;
        for (int cyc = 0; cyc < 3000 && !done; cyc++) begin
            will = if_m.din_valid & if_m.din_ready;
            @(negedge clk);
            if (will) begin
                sent++;
                if (sent < 256) if_m.din = sent[7:0];
                else if_m.din_valid = 1'b0;
            end
            if (prev_last) begin
                if (lasts == 255) begin
                    total++; if (wc_m !== 8'd255) begin bad++; $display("FAIL wrap_255 got=%0d exp=255", wc_m); end
                end
                if (lasts == 256) begin
                    total++; if (wc_m !== 8'd0) begin bad++; $display("FAIL wrap_0 got=%0d exp=0", wc_m); end
                    done = 1'b1;
                end
            end
            prev_last = if_m.x_last;
            if (if_m.x_last) lasts++;
        end
        if_m.din_valid = 1'b0;
        total++; if (done !== 1'b1) begin bad++; $display("FAIL wrap_timeout got=%0d words exp=256", lasts); end
        total++; if (sent !== 256) begin bad++; $display("FAIL wrap_accepts got=%0d exp=256", sent); end
    endtask

    initial begin
        if_m.din = 8'h00;
        if_m.din_valid = 1'b0;
        if_l.din = 8'h00;
        if_l.din_valid = 1'b0;
        test_reset();
        test_single_word();
        test_back_to_back();
        test_lsb_first();
        test_reset_mid_word();
        test_counter_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
